flit_delta_encoder: RTL and testbench
=====================================

Name: flit_delta_encoder

Overview:
- Consumes a 128-bit flit plus the min/max chunk values that the combinational min/max tree produces for it in the same cycle.
- Produces a base-delta compressed flit in two pipeline stages:
  - header = base (min) + delta width k;
  - then 16 deltas of k bits each, packed LSB-first.
- Falls back to the raw flit when compression would not shrink it.
- Sits directly downstream of the min/max tree and feeds the NoC injection buffer over a valid/ready handshake.

Parameters:
- NUM_OF_BITS, 128, flit width.
- CHUNK_SIZE, 8, chunk width in bits; NUM_OF_CHUNKS = NUM_OF_BITS/CHUNK_SIZE = 16.
- K_BITS, 4, width of the delta-width field in the header.
- HDR_BITS, 12, CHUNK_SIZE + K_BITS.
- OUT_BITS, 140, HDR_BITS + NUM_OF_BITS (worst-case packed size).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream flit, min and max are valid.
- in_ready  out  1  encoder accepts this cycle.
- in_flit  in  NUM_OF_BITS  raw flit; chunk i = bits [i*8+7:i*8].
- in_min  in  CHUNK_SIZE  minimum chunk of in_flit (unsigned).
- in_max  in  CHUNK_SIZE  maximum chunk of in_flit (unsigned).
- out_valid  out  1  encoded flit available.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_BITS  packed encoded flit; bits at or above out_len are zero.
- out_len  out  8  number of meaningful bits in out_data (12..128).
- out_compressed  out  1  1 = base-delta format, 0 = raw flit in out_data[127:0].
- cnt_flits  out  CNT_W  flits delivered (out handshakes), saturating.
- cnt_comp  out  CNT_W  compressed flits delivered, saturating.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): both stage-valid flags are 0, and out_valid=0, out_data=0, out_len=0, out_compressed=0, cnt_flits=0, cnt_comp=0.
  - In-flight flits are dropped; no partial output appears.
  - in_ready=1 in the first cycle after reset deasserts.
- Stage S1 (register): captures in_flit, base = in_min, range = in_max - in_min (8-bit unsigned; in_max >= in_min is guaranteed upstream and not checked).
  - k is computed combinationally from the registered range: k = 0 if range==0, else floor(log2(range))+1, so k is 0..8.
  - Example mappings: range 1 -> k 1; range 127 -> k 7; range 128 -> k 8.
- Stage S2 (output register, drives all out_* ports):
  - If k<=7: out_compressed=1, out_data[7:0]=base, out_data[11:8]=k, delta_i = chunk_i - base placed at bits [12+i*k +: k] for i=0..15, out_len = 12+16*k.
  - If k==8: out_compressed=0, out_data[127:0]=flit, out_len=128.
  - All unused upper bits of out_data are 0.
- Latency: in handshake at cycle T -> out_valid at T+2 when there is no backpressure. Throughput is 1 flit/cycle.
- Handshake:
  - in_ready = !s1_valid || s1_move, where s1_move = s1_valid && (!out_valid || out_ready).
  - S2 loads when s1_move; out_valid drops after a handshake when S1 is empty.
  - While out_valid && !out_ready, every out_* port is held stable.
  - Holding at most 2 flits is correct: no overflow, no loss, no duplication, order preserved.
- Simultaneous events: an out handshake, an S1->S2 move and an in handshake in the same cycle all happen; the pipeline stays full.
- Counters:
  - cnt_flits increments on each out_valid && out_ready.
  - cnt_comp increments on the same condition when out_compressed=1.
  - Both saturate at 2^CNT_W-1 with no wrap.
- Input values are ignored when in_valid=0 or in_ready=0.

Decomposition:
- Package flitzip_pkg holds NUM_OF_BITS, CHUNK_SIZE, NUM_OF_CHUNKS, K_BITS, HDR_BITS, OUT_BITS and a function delta_width(range) returning k.
- One sub-module, delta_packer: a combinational function of flit, base and k producing out_data, out_len and out_compressed. It is instantiated between S1 and the S2 register.

Test Plan:
- All chunks 0x05, min=max=0x05 -> 2 cycles later out_compressed=1, k=0, out_len=12, out_data[7:0]=0x05, out_data[11:8]=0, out_data[139:12]=0.
- chunk_i = 0x10+i (min 0x10, max 0x1F) -> k=4, out_len=76, nibble at [12+4i +: 4] = i; cnt_comp becomes 1 after the handshake.
- Chunks containing 0x00 and 0x80 (range 128) -> out_compressed=0, out_len=128, out_data[127:0]=in_flit. Range 127 (0x01/0x80) -> k=7, out_len=124.
- out_ready=0 for 6 cycles while in_valid=1 with 4 distinct flits -> only 2 accepted, in_ready=0, out_* stable. Then out_ready=1 -> all 4 emitted in order on consecutive cycles, cnt_flits=4.
- Continuous in_valid/out_ready=1 for 20 flits -> one output per cycle from cycle 2, no bubbles.
- rst=1 for 1 cycle with 2 flits in flight -> next cycle out_valid=0, counters 0, in_ready=1; the following flit encodes correctly.

Source files
------------

// File: rtl/flitzip_pkg.sv
// Shared widths, types and the delta-width helper used by the base-delta flit encoder.
package flitzip_pkg;

    localparam int NUM_OF_BITS   = 128;
    localparam int CHUNK_SIZE    = 8;
    localparam int NUM_OF_CHUNKS = NUM_OF_BITS / CHUNK_SIZE;
    localparam int K_BITS        = 4;
    localparam int HDR_BITS      = CHUNK_SIZE + K_BITS;
    localparam int OUT_BITS      = HDR_BITS + NUM_OF_BITS;
    localparam int CNT_W         = 16;
    localparam int LEN_W         = 8;

    typedef logic [CHUNK_SIZE-1:0] chunk_t;
    typedef logic [K_BITS-1:0]     kw_t;
    typedef logic [NUM_OF_BITS-1:0] flit_t;
    typedef logic [OUT_BITS-1:0]   enc_data_t;
    typedef logic [LEN_W-1:0]      enc_len_t;

    // k = bit position of the highest set bit plus one; 0 for an all-zero range.
    function automatic kw_t delta_width(input chunk_t range);
        kw_t k;
        k = '0;
        for (int b = 0; b < CHUNK_SIZE; b++) begin
            if (range[b]) k = kw_t'(b + 1);
        end
        return k;
    endfunction

endpackage

// File: rtl/flit_delta_encoder_if.sv
// Upstream (flit + min/max) and downstream (encoded flit) handshake bundle of the encoder.
interface flit_delta_encoder_if;
    import flitzip_pkg::*;

    logic      in_valid;
    logic      in_ready;
    flit_t     in_flit;
    chunk_t    in_min;
    chunk_t    in_max;

    logic      out_valid;
    logic      out_ready;
    enc_data_t out_data;
    enc_len_t  out_len;
    logic      out_compressed;

    // master: the environment around the encoder (min/max tree upstream, injection buffer downstream)
    modport master (
        output in_valid, in_flit, in_min, in_max, out_ready,
        input  in_ready, out_valid, out_data, out_len, out_compressed
    );

    // slave: the encoder itself
    modport slave (
        input  in_valid, in_flit, in_min, in_max, out_ready,
        output in_ready, out_valid, out_data, out_len, out_compressed
    );

endinterface

// File: rtl/delta_packer.sv
// Combinational base-delta packer: header {k, base} followed by 16 k-bit deltas, LSB-first,
// or the raw flit when an 8-bit delta would not shrink the flit.
module delta_packer
    import flitzip_pkg::*;
(
    input  flit_t     flit,
    input  chunk_t    base,
    input  kw_t       k,
    output enc_data_t data,
    output enc_len_t  len,
    output logic      compressed
);

    flit_t  payload;
    chunk_t mask;
    chunk_t delta;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves one
    // unassigned (that would infer a latch); blocking '=' is used because later statements
    // must see the updated payload within the same evaluation.
    always_comb begin
        payload    = '0;
        delta      = '0;
        mask       = ~(chunk_t'('1) << k);
        data       = '0;
        len        = '0;
        compressed = 1'b0;

        // Walk from the top chunk down so chunk 0 lands in the lowest k bits.
        for (int i = NUM_OF_CHUNKS - 1; i >= 0; i--) begin
            delta   = flit[i*CHUNK_SIZE +: CHUNK_SIZE] - base;
            payload = (payload << k) | flit_t'(delta & mask);
        end

        if (k >= kw_t'(CHUNK_SIZE)) begin
            data       = enc_data_t'(flit);
            len        = enc_len_t'(NUM_OF_BITS);
            compressed = 1'b0;
        end else begin
            data       = {payload, k, base};
            len        = enc_len_t'(HDR_BITS) + enc_len_t'(k) * enc_len_t'(NUM_OF_CHUNKS);
            compressed = 1'b1;
        end
    end

endmodule

// File: rtl/flit_delta_encoder.sv
// Two-stage base-delta flit encoder: S1 captures flit/base/range, S2 registers the packed result.
// Sits between the min/max tree and the NoC injection buffer.
module flit_delta_encoder
    import flitzip_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    flit_delta_encoder_if.slave  bus,
    output logic [CNT_W-1:0]     cnt_flits,
    output logic [CNT_W-1:0]     cnt_comp
);

    logic      s1_valid;
    flit_t     s1_flit;
    chunk_t    s1_base;
    chunk_t    s1_range;
    kw_t       s1_k;

    logic      in_ready;
    logic      in_fire;
    logic      s1_move;
    logic      out_fire;

    enc_data_t enc_data;
    enc_len_t  enc_len;
    logic      enc_compressed;

    logic      out_valid_q;
    enc_data_t out_data_q;
    enc_len_t  out_len_q;
    logic      out_compressed_q;

    // S1 empties into S2 whenever S2 is empty or is being drained this cycle.
    assign s1_move  = s1_valid && (!out_valid_q || bus.out_ready);
    assign in_ready = !s1_valid || s1_move;
    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = out_valid_q && bus.out_ready;

    assign s1_k = delta_width(s1_range);

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
        end else if (s1_move) begin
            s1_valid <= 1'b0;
        end
    end

    // NOTE: the S1 payload is not reset; it is only observed while s1_valid is set.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_flit  <= bus.in_flit;
            s1_base  <= bus.in_min;
            s1_range <= bus.in_max - bus.in_min;
        end
    end

    delta_packer u_packer (
        .flit       (s1_flit),
        .base       (s1_base),
        .k          (s1_k),
        .data       (enc_data),
        .len        (enc_len),
        .compressed (enc_compressed)
    );

    // S2 holds its contents while stalled, so every out_* port stays stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q      <= 1'b0;
            out_data_q       <= '0;
            out_len_q        <= '0;
            out_compressed_q <= 1'b0;
        end else if (s1_move) begin
            out_valid_q      <= 1'b1;
            out_data_q       <= enc_data;
            out_len_q        <= enc_len;
            out_compressed_q <= enc_compressed;
        end else if (out_fire) begin
            out_valid_q      <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_flits <= '0;
            cnt_comp  <= '0;
        end else if (out_fire) begin
            if (cnt_flits != '1) cnt_flits <= cnt_flits + 1'b1;
            if (out_compressed_q && cnt_comp != '1) cnt_comp <= cnt_comp + 1'b1;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_data       = out_data_q;
    assign bus.out_len        = out_len_q;
    assign bus.out_compressed = out_compressed_q;

endmodule

// File: tb/tb_flit_delta_encoder.sv
// Directed + randomized bench for flit_delta_encoder with a chunk-level reference model and scoreboard.
module tb_flit_delta_encoder;
    import flitzip_pkg::*;

    typedef logic [OUT_BITS-1:0] val_t;

    typedef struct packed {
        enc_data_t data;
        enc_len_t  len;
        logic      comp;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] cnt_flits;
    logic [CNT_W-1:0] cnt_comp;

    flit_delta_encoder_if bus ();

    flit_delta_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .cnt_flits (cnt_flits),
        .cnt_comp  (cnt_comp)
    );

    always #5 clk = ~clk;

    exp_t      sb[$];
    int        passed = 0;
    int        total  = 0;
    int        exp_flits = 0;
    int        exp_comp  = 0;
    int        accepted  = 0;
    int        emitted   = 0;
    bit        hold_pending = 1'b0;
    enc_data_t hold_data;
    enc_len_t  hold_len;
    logic      hold_comp;

    task automatic check(input string tag, input val_t obs, input val_t exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: min/max over chunks, smallest k with 2^k > range, bit-by-bit packing.
    function automatic exp_t model(input flit_t f);
        exp_t e;
        int   mn, mx, rng, k, v, d;
        mn = 255; mx = 0;
        for (int c = 0; c < NUM_OF_CHUNKS; c++) begin
            v = int'(f[c*8 +: 8]);
            if (v < mn) mn = v;
            if (v > mx) mx = v;
        end
        rng = mx - mn;
        k = 0;
        while (k < 8 && (1 << k) <= rng) k++;
        e.data = '0;
        if (k == 8) begin
            e.data[127:0] = f;
            e.len  = 8'd128;
            e.comp = 1'b0;
        end else begin
            e.data[7:0]  = 8'(mn);
            e.data[11:8] = 4'(k);
            for (int i = 0; i < NUM_OF_CHUNKS; i++) begin
                d = int'(f[i*8 +: 8]) - mn;
                for (int b = 0; b < k; b++) e.data[12 + i*k + b] = d[b];
            end
            e.len  = 8'(12 + 16*k);
            e.comp = 1'b1;
        end
        return e;
    endfunction

    function automatic flit_t rand_flit();
        flit_t f;
        int    base, span, v;
        base = int'($urandom_range(0, 255));
        span = (1 << $urandom_range(0, 8)) - 1;
        for (int c = 0; c < NUM_OF_CHUNKS; c++) begin
            v = base + int'($urandom & span);
            if (v > 255) v = 255;
            f[c*8 +: 8] = 8'(v);
        end
        return f;
    endfunction

    // Plays the min/max tree: presents the flit with its true min and max chunk.
    task automatic drive(input bit v, input flit_t f);
        int mn, mx;
        mn = 255; mx = 0;
        for (int c = 0; c < NUM_OF_CHUNKS; c++) begin
            if (int'(f[c*8 +: 8]) < mn) mn = int'(f[c*8 +: 8]);
            if (int'(f[c*8 +: 8]) > mx) mx = int'(f[c*8 +: 8]);
        end
        bus.in_valid = v;
        bus.in_flit  = f;
        bus.in_min   = 8'(mn);
        bus.in_max   = 8'(mx);
    endtask

    // One clock: observe handshakes at the falling edge, then step past the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (hold_pending) begin
                check("hold_data", bus.out_data, hold_data);
                check("hold_len", val_t'(bus.out_len), val_t'(hold_len));
                check("hold_comp", val_t'(bus.out_compressed), val_t'(hold_comp));
            end
            if (bus.out_valid && bus.out_ready) begin
                emitted++;
                if (exp_flits < 65535) exp_flits++;
                if (sb.size() == 0) begin
                    check("spurious_out", val_t'(bus.out_valid), val_t'(0));
                end else begin
                    e = sb.pop_front();
                    check("sb_data", bus.out_data, e.data);
                    check("sb_len", val_t'(bus.out_len), val_t'(e.len));
                    check("sb_comp", val_t'(bus.out_compressed), val_t'(e.comp));
                    if (e.comp && exp_comp < 65535) exp_comp++;
                end
            end
            hold_pending = bus.out_valid && !bus.out_ready;
            hold_data    = bus.out_data;
            hold_len     = bus.out_len;
            hold_comp    = bus.out_compressed;
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(model(bus.in_flit));
                accepted++;
            end
        end else begin
            hold_pending = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        drive(1'b0, '0);
        repeat (cycles) tick();
        rst = 1'b0;
        sb.delete();
        exp_flits = 0;
        exp_comp  = 0;
    endtask

    // Sends one flit with an idle downstream, checks 2-cycle latency and the headline fields.
    // Leaves the result presented; the caller's next tick() consumes it.
    task automatic send_known(input string tag, input flit_t f, input int len, input bit comp);
        bus.out_ready = 1'b1;
        drive(1'b1, f);
        tick();
        drive(1'b0, '0);
        check({tag, "_not_yet"}, val_t'(bus.out_valid), val_t'(0));
        tick();
        check({tag, "_valid"}, val_t'(bus.out_valid), val_t'(1));
        check({tag, "_len"}, val_t'(bus.out_len), val_t'(len));
        check({tag, "_comp"}, val_t'(bus.out_compressed), val_t'(comp));
    endtask

    initial begin
        flit_t     f;
        flit_t     bp[4];
        enc_data_t e;
        int        idx, a, acc0, emit0;

        rst = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b0, '0);
        do_reset(2);

        check("rst_out_valid", val_t'(bus.out_valid), val_t'(0));
        check("rst_out_data", bus.out_data, val_t'(0));
        check("rst_out_len", val_t'(bus.out_len), val_t'(0));
        check("rst_out_comp", val_t'(bus.out_compressed), val_t'(0));
        check("rst_cnt_flits", val_t'(cnt_flits), val_t'(0));
        check("rst_cnt_comp", val_t'(cnt_comp), val_t'(0));
        check("rst_in_ready", val_t'(bus.in_ready), val_t'(1));

        // Uniform flit: k = 0, header only.
        send_known("uniform", {16{8'h05}}, 12, 1'b1);
        check("uniform_data", bus.out_data, val_t'(12'h005));
        tick();
        check("uniform_cnt_comp", val_t'(cnt_comp), val_t'(1));

        // Ascending chunks 0x10..0x1F: k = 4, nibble i holds i.
        for (int i = 0; i < NUM_OF_CHUNKS; i++) f[i*8 +: 8] = 8'(8'h10 + i);
        e = '0;
        e[7:0]  = 8'h10;
        e[11:8] = 4'd4;
        for (int i = 0; i < NUM_OF_CHUNKS; i++) e[12 + 4*i +: 4] = 4'(i);
        send_known("ramp", f, 76, 1'b1);
        check("ramp_data", bus.out_data, e);
        tick();
        check("ramp_cnt_comp", val_t'(cnt_comp), val_t'(exp_comp));

        // Range 128 falls back to raw.
        f = {16{8'h40}};
        f[7:0]   = 8'h00;
        f[31:24] = 8'h80;
        send_known("raw128", f, 128, 1'b0);
        check("raw128_data", bus.out_data, val_t'(f));
        tick();

        // Range 127 is the widest compressible case.
        f = {16{8'h20}};
        f[7:0]   = 8'h01;
        f[63:56] = 8'h80;
        send_known("k7", f, 124, 1'b1);
        tick();

        // Backpressure: 6 stalled cycles with four distinct flits offered.
        do_reset(1);
        for (int i = 0; i < 4; i++) bp[i] = rand_flit() ^ flit_t'(i + 1);
        bus.out_ready = 1'b0;
        idx  = 0;
        acc0 = accepted;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, bp[idx]);
            a = accepted;
            tick();
            if (accepted > a) idx++;
        end
        check("bp_accepted", val_t'(accepted - acc0), val_t'(2));
        check("bp_in_ready", val_t'(bus.in_ready), val_t'(0));
        check("bp_out_valid", val_t'(bus.out_valid), val_t'(1));
        bus.out_ready = 1'b1;
        emit0 = emitted;
        for (int c = 0; c < 4; c++) begin
            if (idx < 4) drive(1'b1, bp[idx]);
            else drive(1'b0, '0);
            check("bp_drain_valid", val_t'(bus.out_valid), val_t'(1));
            a = accepted;
            tick();
            if (accepted > a) idx++;
        end
        check("bp_emitted", val_t'(emitted - emit0), val_t'(4));
        check("bp_cnt_flits", val_t'(cnt_flits), val_t'(4));
        check("bp_idle", val_t'(bus.out_valid), val_t'(0));

        // Full-rate streaming: no bubbles from cycle 2 on.
        emit0 = emitted;
        for (int c = 0; c < 22; c++) begin
            if (c < 20) drive(1'b1, rand_flit());
            else drive(1'b0, '0);
            if (c < 20) check("stream_in_ready", val_t'(bus.in_ready), val_t'(1));
            if (c >= 2) check("stream_out_valid", val_t'(bus.out_valid), val_t'(1));
            tick();
        end
        check("stream_emitted", val_t'(emitted - emit0), val_t'(20));
        check("stream_drained", val_t'(bus.out_valid), val_t'(0));

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            drive(1'($urandom_range(0, 1)), rand_flit());
            tick();
        end
        bus.out_ready = 1'b1;
        drive(1'b0, '0);
        repeat (4) tick();
        check("rand_sb_empty", val_t'(sb.size()), val_t'(0));
        check("rand_cnt_flits", val_t'(cnt_flits), val_t'(exp_flits));
        check("rand_cnt_comp", val_t'(cnt_comp), val_t'(exp_comp));

        // Reset with two flits in flight.
        bus.out_ready = 1'b0;
        acc0 = accepted;
        for (int c = 0; c < 4 && accepted - acc0 < 2; c++) begin
            drive(1'b1, rand_flit());
            tick();
        end
        check("flight_loaded", val_t'(accepted - acc0), val_t'(2));
        do_reset(1);
        check("flight_out_valid", val_t'(bus.out_valid), val_t'(0));
        check("flight_cnt_flits", val_t'(cnt_flits), val_t'(0));
        check("flight_cnt_comp", val_t'(cnt_comp), val_t'(0));
        check("flight_in_ready", val_t'(bus.in_ready), val_t'(1));
        f = {16{8'h33}};
        f[23:16] = 8'h35;
        send_known("post_rst", f, 44, 1'b1);
        tick();
        check("post_rst_cnt", val_t'(cnt_flits), val_t'(1));

        // Counter saturation.
        bus.out_ready = 1'b1;
        for (int c = 0; c < 65540; c++) begin
            drive(1'b1, '0);
            tick();
        end
        drive(1'b0, '0);
        repeat (3) tick();
        check("sat_cnt_flits", val_t'(cnt_flits), val_t'(16'hFFFF));
        check("sat_cnt_comp", val_t'(cnt_comp), val_t'(16'hFFFF));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
